wb_writeback_arbiter: RTL and testbench

//  Writeback stage directly upstream of the register file. Merges results from the

---
 rtl/wb_writeback_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_writeback_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_arbiter.sv
// Writeback arbiter: merges ALU (port A) and load (port L) results onto the
// single register-file write port. Round-robin on contention, load byte/half
// extraction with sign/zero extension, misalignment and illegal-type detection,
// registered outputs and a retired-write counter.
module wb_writeback_arbiter #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [RA_W-1:0]  a_rd,
    input  logic [XLEN-1:0]  a_data,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic [RA_W-1:0]  l_rd,
    input  logic [XLEN-1:0]  l_data,
    input  logic [1:0]       l_addr_lo,
    input  logic [2:0]       l_funct3,
    output logic             rf_wr_en,
    output logic [RA_W-1:0]  rf_rd,
    output logic [XLEN-1:0]  rf_wr_data,
    output logic             ld_err,
    output logic [CNT_W-1:0] retire_cnt
);

    // Which source won the most recent grant; the other one wins a tie.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_L = 1'b1
    } src_e;

    src_e             last_grant_q, last_grant_d;
    logic             wr_en_q, wr_en_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_a_s, grant_l_s;
    logic             ld_bad_s;
    logic [XLEN-1:0]  ld_val_s;

    // Select byte/halfword from the aligned word and extend it to XLEN.
    function automatic logic [XLEN-1:0] ld_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      addr,
                                                   input logic [2:0]      f3);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        b = word[{addr, 3'b000} +: 8];
        h = word[{addr[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{(XLEN-8){b[7]}}, b};
            3'b001:  res = {{(XLEN-16){h[15]}}, h};
            3'b100:  res = {{(XLEN-8){1'b0}}, b};
            3'b101:  res = {{(XLEN-16){1'b0}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // A load is bad when misaligned for its size or its type code is not a load.
    function automatic logic ld_bad(input logic [1:0] addr, input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = addr[0];
            3'b010:         bad = (addr != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign ld_bad_s = ld_bad(l_addr_lo, l_funct3);
    assign ld_val_s = ld_extract(l_data, l_addr_lo, l_funct3);

    // Round-robin grant; nothing is accepted while reset is asserted.
    always_comb begin
        grant_a_s = 1'b0;
        grant_l_s = 1'b0;
        if (!rst_n) begin
            grant_a_s = 1'b0;
            grant_l_s = 1'b0;
        end else if (a_valid && l_valid) begin
            if (last_grant_q == SRC_L) begin
                grant_a_s = 1'b1;
            end else begin
                grant_l_s = 1'b1;
            end
        end else begin
            grant_a_s = a_valid;
            grant_l_s = l_valid;
        end
    end

    assign a_ready = grant_a_s;
    assign l_ready = grant_l_s;

    // Next-state for the registered write port, error pulse and counter.
    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        rd_d         = rd_q;
        data_d       = data_q;
        err_d        = 1'b0;
        if (grant_a_s) begin
            last_grant_d = SRC_A;
            wr_en_d      = (a_rd != {RA_W{1'b0}});
            rd_d         = a_rd;
            data_d       = a_data;
        end else if (grant_l_s) begin
            last_grant_d = SRC_L;
            err_d        = ld_bad_s;
            wr_en_d      = !ld_bad_s && (l_rd != {RA_W{1'b0}});
            rd_d         = l_rd;
            data_d       = ld_val_s;
        end else begin
            last_grant_d = last_grant_q;
        end
        if (wr_en_d) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset; in-flight result is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= SRC_L;
            wr_en_q      <= 1'b0;
            rd_q         <= {RA_W{1'b0}};
            data_q       <= {XLEN{1'b0}};
            err_q        <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_rd      = rd_q;
    assign rf_wr_data = data_q;
    assign ld_err     = err_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_writeback_arbiter.sv
// Self-checking bench for wb_writeback_arbiter: directed vector table,
// randomized run against a behavioural model, and a counter-wrap sequence
// on a narrow-counter second instance sharing the same inputs.
module tb_wb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid, l_valid;
    logic [4:0]  a_rd, l_rd;
    logic [31:0] a_data, l_data;
    logic [1:0]  l_addr_lo;
    logic [2:0]  l_funct3;
    logic        a_ready, l_ready, rf_wr_en, ld_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wr_data;
    logic [15:0] retire_cnt;
    logic        s_a_ready, s_l_ready, s_wr_en, s_ld_err;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [3:0]  s_cnt;

    int vectors = 0;
    int miscompares = 0;

    wb_writeback_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .l_addr_lo(l_addr_lo), .l_funct3(l_funct3),
        .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data),
        .ld_err(ld_err), .retire_cnt(retire_cnt)
    );

    wb_writeback_arbiter #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(s_a_ready), .a_rd(a_rd), .a_data(a_data),
        .l_valid(l_valid), .l_ready(s_l_ready), .l_rd(l_rd), .l_data(l_data),
        .l_addr_lo(l_addr_lo), .l_funct3(l_funct3),
        .rf_wr_en(s_wr_en), .rf_rd(s_rd), .rf_wr_data(s_data),
        .ld_err(s_ld_err), .retire_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [1:0]  laddr;
        logic [2:0]  lf3;
        logic        ear;
        logic        elr;
        logic        ewr;
        logic        chk_rd;
        logic [4:0]  erd;
        logic [31:0] edata;
        logic        eerr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n     = v.rst_n;
        a_valid   = v.av;
        a_rd      = v.ard;
        a_data    = v.adata;
        l_valid   = v.lv;
        l_rd      = v.lrd;
        l_data    = v.ldata;
        l_addr_lo = v.laddr;
        l_funct3  = v.lf3;
    endtask

    task automatic add(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic [1:0] la, input logic [2:0] lf,
                       input logic ear, input logic elr, input logic ewr, input logic chk,
                       input logic [4:0] erd, input logic [31:0] ed, input logic eerr,
                       input logic [15:0] ecnt);
        vec_t v;
        v.rst_n = r; v.av = av; v.ard = ard; v.adata = ad;
        v.lv = lv; v.lrd = lrd; v.ldata = ld; v.laddr = la; v.lf3 = lf;
        v.ear = ear; v.elr = elr; v.ewr = ewr; v.chk_rd = chk;
        v.erd = erd; v.edata = ed; v.eerr = eerr; v.ecnt = ecnt;
        vq.push_back(v);
    endtask

    // Reference load result computed arithmetically from the load-type rules.
    function automatic logic [31:0] model_load(input logic [31:0] w, input int a, input int f3);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'h0000_00FF;
        h = (w >> (16 * (a / 2))) & 32'h0000_FFFF;
        case (f3)
            0:       return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            1:       return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            4:       return b;
            5:       return h;
            default: return w;
        endcase
    endfunction

    function automatic bit model_bad(input int a, input int f3);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    localparam logic [31:0] LD = 32'h80F1_7F82;

    initial begin
        vec_t v;
        bit   a_won_last, ga, gl, bad;
        bit   e_wr, e_err;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        int   e_cnt;

        rst_n = 1'b0; a_valid = 1'b0; l_valid = 1'b0; a_rd = 5'd0; l_rd = 5'd0;
        a_data = 32'd0; l_data = 32'd0; l_addr_lo = 2'd0; l_funct3 = 3'd0;

        //  rst av ard   adata         lv lrd  ldata         la    lf3     ear  elr  ewr  chk  erd    edata         err  cnt
        add(0, 1, 5'd5, 32'h1,        0, 5'd0, 32'h0,       2'd0, 3'd0, 0, 0, 0, 1, 5'd0, 32'h0,        0, 16'd0);
        add(0, 1, 5'd5, 32'h1,        0, 5'd0, 32'h0,       2'd0, 3'd0, 0, 0, 0, 1, 5'd0, 32'h0,        0, 16'd0);
        add(0, 1, 5'd5, 32'h1,        0, 5'd0, 32'h0,       2'd0, 3'd0, 0, 0, 0, 1, 5'd0, 32'h0,        0, 16'd0);
        add(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,       2'd0, 3'd0, 1, 0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 16'd1);
        add(1, 0, 5'd0, 32'h0,        1, 5'd3, 32'h12345678,2'd0, 3'd2, 0, 1, 1, 1, 5'd3, 32'h12345678, 0, 16'd2);
        add(1, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222,2'd0, 3'd2, 1, 0, 1, 1, 5'd1, 32'h11111111, 0, 16'd3);
        add(1, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222,2'd0, 3'd2, 0, 1, 1, 1, 5'd2, 32'h22222222, 0, 16'd4);
        add(1, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222,2'd0, 3'd2, 1, 0, 1, 1, 5'd1, 32'h11111111, 0, 16'd5);
        add(1, 1, 5'd1, 32'h11111111, 1, 5'd2, 32'h22222222,2'd0, 3'd2, 0, 1, 1, 1, 5'd2, 32'h22222222, 0, 16'd6);
        add(1, 0, 5'd0, 32'h0,        1, 5'd10, LD,         2'd0, 3'd0, 0, 1, 1, 1, 5'd10, 32'hFFFFFF82, 0, 16'd7);
        add(1, 0, 5'd0, 32'h0,        1, 5'd10, LD,         2'd0, 3'd4, 0, 1, 1, 1, 5'd10, 32'h00000082, 0, 16'd8);
        add(1, 0, 5'd0, 32'h0,        1, 5'd10, LD,         2'd2, 3'd1, 0, 1, 1, 1, 5'd10, 32'hFFFF80F1, 0, 16'd9);
        add(1, 0, 5'd0, 32'h0,        1, 5'd10, LD,         2'd2, 3'd5, 0, 1, 1, 1, 5'd10, 32'h000080F1, 0, 16'd10);
        add(1, 0, 5'd0, 32'h0,        1, 5'd10, LD,         2'd1, 3'd0, 0, 1, 1, 1, 5'd10, 32'h0000007F, 0, 16'd11);
        add(1, 0, 5'd0, 32'h0,        1, 5'd7, LD,          2'd2, 3'd2, 0, 1, 0, 0, 5'd0, 32'h0,        1, 16'd11);
        add(1, 0, 5'd0, 32'h0,        1, 5'd7, LD,          2'd0, 3'd3, 0, 1, 0, 0, 5'd0, 32'h0,        1, 16'd11);
        add(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       2'd0, 3'd0, 0, 0, 0, 0, 5'd0, 32'h0,        0, 16'd11);
        add(1, 1, 5'd0, 32'hAAAA,     0, 5'd0, 32'h0,       2'd0, 3'd0, 1, 0, 0, 0, 5'd0, 32'h0,        0, 16'd11);
        add(1, 1, 5'd9, 32'h99,       0, 5'd0, 32'h0,       2'd0, 3'd0, 1, 0, 1, 1, 5'd9, 32'h99,       0, 16'd12);
        add(1, 1, 5'd4, 32'h44,       0, 5'd0, 32'h0,       2'd0, 3'd0, 1, 0, 1, 1, 5'd4, 32'h44,       0, 16'd13);
        add(0, 1, 5'd6, 32'h66,       0, 5'd0, 32'h0,       2'd0, 3'd0, 0, 0, 0, 1, 5'd0, 32'h0,        0, 16'd0);
        add(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,       2'd0, 3'd0, 0, 0, 0, 1, 5'd0, 32'h0,        0, 16'd0);

        @(posedge clk);
        #1;
        foreach (vq[i]) begin
            drive(vq[i]);
            #1;
            check($sformatf("v%0d a_ready", i), {31'd0, a_ready}, {31'd0, vq[i].ear});
            check($sformatf("v%0d l_ready", i), {31'd0, l_ready}, {31'd0, vq[i].elr});
            @(posedge clk);
            #1;
            check($sformatf("v%0d rf_wr_en", i), {31'd0, rf_wr_en}, {31'd0, vq[i].ewr});
            check($sformatf("v%0d ld_err", i), {31'd0, ld_err}, {31'd0, vq[i].eerr});
            check($sformatf("v%0d retire_cnt", i), {16'd0, retire_cnt}, {16'd0, vq[i].ecnt});
            check($sformatf("v%0d small_cnt", i), {28'd0, s_cnt}, {28'd0, vq[i].ecnt[3:0]});
            if (vq[i].chk_rd) begin
                check($sformatf("v%0d rf_rd", i), {27'd0, rf_rd}, {27'd0, vq[i].erd});
                check($sformatf("v%0d rf_wr_data", i), rf_wr_data, vq[i].edata);
            end
        end

        // Randomized run: last table vector left the design freshly reset.
        a_won_last = 1'b0; e_wr = 1'b0; e_err = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            v.rst_n = ($urandom_range(0, 39) != 0);
            v.av    = $urandom_range(0, 1);
            v.ard   = 5'($urandom_range(0, 31));
            v.adata = $urandom;
            v.lv    = $urandom_range(0, 1);
            v.lrd   = 5'($urandom_range(0, 31));
            v.ldata = $urandom;
            v.laddr = 2'($urandom_range(0, 3));
            v.lf3   = 3'($urandom_range(0, 7));
            ga = 1'b0; gl = 1'b0;
            if (v.rst_n) begin
                if (v.av && v.lv) begin
                    ga = !a_won_last;
                    gl = a_won_last;
                end else begin
                    ga = v.av;
                    gl = v.lv;
                end
            end
            drive(v);
            #1;
            check("rnd a_ready", {31'd0, a_ready}, {31'd0, ga});
            check("rnd l_ready", {31'd0, l_ready}, {31'd0, gl});
            @(posedge clk);
            #1;
            if (!v.rst_n) begin
                a_won_last = 1'b0; e_wr = 1'b0; e_err = 1'b0; e_rd = 5'd0; e_data = 32'd0; e_cnt = 0;
            end else if (ga) begin
                a_won_last = 1'b1; e_err = 1'b0;
                e_wr = (v.ard != 5'd0); e_rd = v.ard; e_data = v.adata;
            end else if (gl) begin
                a_won_last = 1'b0;
                bad = model_bad(int'(v.laddr), int'(v.lf3));
                e_err = bad;
                e_wr = !bad && (v.lrd != 5'd0);
                e_rd = v.lrd;
                e_data = model_load(v.ldata, int'(v.laddr), int'(v.lf3));
            end else begin
                e_wr = 1'b0; e_err = 1'b0;
            end
            if (e_wr) e_cnt = e_cnt + 1;
            check("rnd rf_wr_en", {31'd0, rf_wr_en}, {31'd0, e_wr});
            check("rnd ld_err", {31'd0, ld_err}, {31'd0, e_err});
            check("rnd retire_cnt", {16'd0, retire_cnt}, e_cnt % 65536);
            check("rnd small_cnt", {28'd0, s_cnt}, e_cnt % 16);
            if (e_wr) begin
                check("rnd rf_rd", {27'd0, rf_rd}, {27'd0, e_rd});
                check("rnd rf_wr_data", rf_wr_data, e_data);
            end
        end

        // Counter wrap on the 4-bit instance: 15 writes, then one more rolls to 0.
        v.rst_n = 1'b0; v.av = 1'b0; v.lv = 1'b0; v.ard = 5'd1; v.adata = 32'h5;
        v.lrd = 5'd0; v.ldata = 32'd0; v.laddr = 2'd0; v.lf3 = 3'd0;
        drive(v);
        @(posedge clk);
        #1;
        v.rst_n = 1'b1; v.av = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            drive(v);
            @(posedge clk);
            #1;
            if (k == 15) check("wrap small_cnt 15", {28'd0, s_cnt}, 32'd15);
        end
        check("wrap small_cnt 0", {28'd0, s_cnt}, 32'd0);
        check("wrap main_cnt 16", {16'd0, retire_cnt}, 32'd16);
        v.ard = 5'd0;
        drive(v);
        @(posedge clk);
        #1;
        check("wrap rd0 no write", {31'd0, rf_wr_en}, 32'd0);
        check("wrap rd0 cnt held", {28'd0, s_cnt}, 32'd0);
        v.av = 1'b0;
        drive(v);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
